// File: rtl/fwd_track_unit.sv
// fwd_track_unit: tracks in-flight register writes across DEPTH post-EX
// stages and forwards the youngest matching value to each of NUM_SRC source
// operands. A load that has not yet reached MEM raises stall_o, and the
// chain takes a bubble in place of the held instruction.
// Optional build macro: FWD_TRACK_PERF_CNT_EN adds saturating stall and
// forward-hit counters (stall_cnt_o, fwd_cnt_o).
module fwd_track_unit #(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter int DEPTH   = 2,
  parameter int NUM_SRC = 2,
  parameter int SEL_W   = $clog2(DEPTH + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      issue_valid_i,
  input  logic [REG_AW-1:0]         issue_rd_i,
  input  logic [XLEN-1:0]           issue_data_i,
  input  logic                      issue_load_i,
  input  logic [XLEN-1:0]           ld_data_i,
  input  logic                      flush_i,
  input  logic [NUM_SRC*REG_AW-1:0] rs_i,
  input  logic [NUM_SRC*XLEN-1:0]   rf_data_i,
  output logic [NUM_SRC*XLEN-1:0]   op_o,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel_o,
`ifdef FWD_TRACK_PERF_CNT_EN
  output logic [31:0]               stall_cnt_o,
  output logic [31:0]               fwd_cnt_o,
`endif
  output logic                      stall_o
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
    logic              ready;
  } entry_t;

  entry_t               chain_q [DEPTH];
  entry_t               chain_d [DEPTH];
  logic [NUM_SRC-1:0]   hazard;
  logic                 stall;
  logic                 push;

`ifdef FWD_TRACK_PERF_CNT_EN
  localparam int CNT_W = $clog2(NUM_SRC + 1);
  logic [NUM_SRC-1:0] hit;
  logic [CNT_W-1:0]   hit_cnt;
  logic [31:0]        stall_cnt_q, stall_cnt_d;
  logic [31:0]        fwd_cnt_q, fwd_cnt_d;
  logic [32:0]        fwd_sum;
`endif

  // Operand lookup against pre-edge state; the youngest match wins even if
  // it is not ready, so a not-ready youngest entry stalls rather than
  // falling back to an older ready one.
  always_comb begin
    // NOTE: every output of this block gets a default before any condition,
    // otherwise a path that skips an assignment would infer a latch.
    op_o      = rf_data_i;
    fwd_sel_o = '0;
    hazard    = '0;
`ifdef FWD_TRACK_PERF_CNT_EN
    hit       = '0;
`endif
    for (int k = 0; k < NUM_SRC; k++) begin
      // Walk oldest to youngest so the youngest match overwrites the rest.
      for (int j = DEPTH - 1; j >= 0; j--) begin
        if ((rs_i[k*REG_AW +: REG_AW] != '0) && chain_q[j].valid &&
            (chain_q[j].rd == rs_i[k*REG_AW +: REG_AW])) begin
          fwd_sel_o[k*SEL_W +: SEL_W] = SEL_W'(j + 1);
          if (chain_q[j].ready) begin
            op_o[k*XLEN +: XLEN] = chain_q[j].data;
            hazard[k]            = 1'b0;
`ifdef FWD_TRACK_PERF_CNT_EN
            hit[k]               = 1'b1;
`endif
          end else begin
            op_o[k*XLEN +: XLEN] = rf_data_i[k*XLEN +: XLEN];
            hazard[k]            = 1'b1;
`ifdef FWD_TRACK_PERF_CNT_EN
            hit[k]               = 1'b0;
`endif
          end
        end
      end
    end
    stall   = |hazard;
    stall_o = stall;
  end

  // Next chain state: push or bubble into entry 0, shift the rest, and let a
  // pending load capture memory data as it leaves entry 0.
  always_comb begin
    push = issue_valid_i & ~flush_i & ~stall;
    for (int j = 0; j < DEPTH; j++) chain_d[j] = '0;
    if (push) begin
      chain_d[0].valid = 1'b1;
      chain_d[0].rd    = issue_rd_i;
      chain_d[0].data  = issue_data_i;
      chain_d[0].ready = ~issue_load_i;
    end
    for (int j = 1; j < DEPTH; j++) begin
      chain_d[j] = chain_q[j-1];
      if (chain_q[j-1].valid && !chain_q[j-1].ready) begin
        chain_d[j].data  = ld_data_i;
        chain_d[j].ready = 1'b1;
      end
    end
  end

  // Chain register; reset clears every field so a stall drops immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of statement order.
    if (rst_i) begin
      for (int j = 0; j < DEPTH; j++) chain_q[j] <= '0;
    end else begin
      for (int j = 0; j < DEPTH; j++) chain_q[j] <= chain_d[j];
    end
  end

`ifdef FWD_TRACK_PERF_CNT_EN
  // Saturating counters for stall cycles and ready-data forwarding hits.
  always_comb begin
    hit_cnt = '0;
    for (int k = 0; k < NUM_SRC; k++) hit_cnt = hit_cnt + CNT_W'(hit[k]);
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
    fwd_sum   = {1'b0, fwd_cnt_q} + 33'(hit_cnt);
    fwd_cnt_d = fwd_sum[32] ? '1 : fwd_sum[31:0];
  end

  // Counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign fwd_cnt_o   = fwd_cnt_q;
`endif

endmodule

// File: doc/fwd_track_unit.md
Name: fwd_track_unit

Overview:
- Parametrised successor to the per-operand forwarding mux: tracks in-flight register writes across DEPTH post-EX pipeline stages and selects forwarded operand values for NUM_SRC source operands.
- Detects load-use hazards internally, raises a stall, and inserts a bubble into its own tracking chain.
- Sits at the EX stage of the CPU pipeline, between register-file read data and the ALU operand inputs.

Parameters:
- XLEN, 32, data width.
- REG_AW, 5, register address width.
- DEPTH, 2, tracked stages after EX. Entry 0 = EX/MEM, entry 1 = MEM/WB, and so on. Legal range 1..8.
- NUM_SRC, 2, number of source operands looked up per cycle. Legal range 1..4.
- SEL_W, $clog2(DEPTH+1), width of each per-operand select field.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- issue_valid_i  in  1  instruction leaving EX writes a register.
- issue_rd_i  in  REG_AW  destination of that instruction.
- issue_data_i  in  XLEN  EX result; ignored for loads.
- issue_load_i  in  1  instruction is a load; its data is not ready until MEM.
- ld_data_i  in  XLEN  load data from memory, valid for the load currently in entry 0.
- flush_i  in  1  discard this cycle's push.
- rs_i  in  NUM_SRC*REG_AW  packed source addresses; operand k is at [k*REG_AW +: REG_AW].
- rf_data_i  in  NUM_SRC*XLEN  packed register-file read values.
- op_o  out  NUM_SRC*XLEN  packed resolved operands.
- fwd_sel_o  out  NUM_SRC*SEL_W  per operand: 0 = register file, j+1 = entry j.
- stall_o  out  1  load-use hazard; the EX instruction must be held.

Behaviour:
- State: DEPTH entries, each holding {valid, rd, data, ready}.
- Reset (async, rst_i=1):
  - All valid=0, ready=0, rd=0, data=0.
  - Consequently stall_o=0, fwd_sel_o=0, op_o=rf_data_i.
- Chain update, every rising edge with rst_i=0:
  - Entry j moves to entry j+1 for j = 0..DEPTH-2.
  - Entry DEPTH-1 is dropped.
  - The chain never back-pressures.
- Load completion:
  - When a valid, not-ready entry 0 moves to entry 1, it captures ld_data_i and sets ready=1.
  - If DEPTH=1 the entry is dropped instead and ld_data_i is unused.
- Push into entry 0:
  - Condition: issue_valid_i & ~flush_i & ~stall_o.
  - Entry 0 gets {1, issue_rd_i, issue_data_i, ~issue_load_i}.
  - Otherwise entry 0 becomes a bubble (valid=0).
  - stall_o therefore inserts a bubble automatically; upstream holds the EX instruction and re-presents it next cycle.
- Lookup, combinational, for each operand k:
  - Find the lowest-index (youngest) entry j with valid=1 and rd==rs_k.
  - rs_k==0 never matches: op_o=rf_data_i (x0 reads 0 from the register file).
  - Match found and ready=1: op_o=data[j], fwd_sel_o=j+1.
  - Match found and ready=0: operand hazard asserted; op_o=rf_data_i; fwd_sel_o=j+1.
  - No match: op_o=rf_data_i, fwd_sel_o=0.
- stall_o = OR of all operand hazards. Only entry 0 can be not-ready.
- Priority: if several entries match, the youngest wins, including when the youngest is not ready (stall; no fallback to an older ready entry).
- Same-edge push and lookup: lookup uses pre-edge state; a value pushed this edge is visible from the next cycle.
- Reset mid-hazard: chain clears immediately; stall_o drops asynchronously.

Optional Feature:
- Macro FWD_TRACK_PERF_CNT_EN.
- When defined, adds outputs:
  - stall_cnt_o [31:0]: increments each cycle with stall_o=1.
  - fwd_cnt_o [31:0]: increments by the number of operands forwarded with ready data this cycle (0..NUM_SRC).
  - Both saturate at 2^32-1 and reset to 0 on rst_i.
- When undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset with rf_data_i={0x22,0x11}, rs_i={3,4} -> op_o={0x22,0x11}, fwd_sel_o=0, stall_o=0; then release reset.
- Push rd=5, data=0xAAAA0001, then rs0=5 -> op0=0xAAAA0001, sel0=1. Next cycle, no push -> sel0=2, same data. One cycle later -> sel0=0, op0=rf.
- Back-to-back pushes rd=7 with 0x1 then rd=7 with 0x2; rs0=rs1=7 -> both operands 0x2, sel=1 (youngest wins).
- Push load rd=9, then rs1=9 -> stall_o=1. At that edge ld_data_i=0xDEAD and issue_valid_i=1 -> no push, bubble in entry 0. Next cycle -> stall_o=0, op1=0xDEAD, sel1=2.
- Push rd=0 with 0xFFFF, rs0=0 -> op0=rf value, sel0=0. Push with flush_i=1 rd=6 -> rs=6 never forwards.
- With FWD_TRACK_PERF_CNT_EN: two hazard cycles plus three forwarding hits -> stall_cnt_o=2, fwd_cnt_o=3. Async reset mid-stall -> stall_o=0 and counters 0 immediately.
